// File: rtl/riscv_fwd_pkg.sv
// Shared definitions for the RV32E hazard/forwarding controller:
// mux select encodings, pipeline slot record and the live-producer test.
package riscv_fwd_pkg;

    localparam int FWD_REG_AW = 4;

    // Operand mux selects as seen by the EX stage
    localparam logic [1:0] FWD_REG    = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [FWD_REG_AW-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    // A slot can only feed a consumer if it really writes a non-x0 register
    function automatic logic slot_live(slot_t s);
        return s.valid & s.reg_write & (s.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding select: youngest live producer wins, loads in EX
// are skipped (they are handled by a stall), x0 and unused operands never forward.
// Ports: i_rs/i_used operand, i_ex_*/i_mem_* producer slots, o_sel mux select.
module fwd_select
    import riscv_fwd_pkg::*;
#(
    parameter int REG_AW = FWD_REG_AW
) (
    input  logic [REG_AW-1:0] i_rs,
    input  logic              i_used,
    input  logic              i_ex_live,
    input  logic              i_ex_mem_read,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_mem_live,
    input  logic [REG_AW-1:0] i_mem_rd,
    output logic [1:0]        o_sel
);

    logic w_want;
    logic w_ex_hit;
    logic w_mem_hit;

    assign w_want    = i_used & (i_rs != '0);
    assign w_ex_hit  = w_want & i_ex_live & ~i_ex_mem_read & (i_rs == i_ex_rd);
    assign w_mem_hit = w_want & i_mem_live & (i_rs == i_mem_rd);

    always_comb begin
        o_sel = FWD_REG;
        if (w_ex_hit) begin
            o_sel = FWD_EX_MEM;
        end else if (w_mem_hit) begin
            o_sel = FWD_MEM_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the RV32E 5-stage pipeline.
// Tracks EX/MEM destinations, registers operand mux selects, stalls on
// load-use, honours freeze (mem_busy_i) and flush (flush_i), counts stalls.
// Ports: clk_i/rst_ni; id_* ID-stage decode; flush_i, mem_busy_i;
// stall_o (comb), fwd_a_o/fwd_b_o, ex_valid_o, stall_cnt_o (registered).
module hazard_fwd_ctrl
    import riscv_fwd_pkg::*;
#(
    parameter int REG_AW = FWD_REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    input  logic              flush_i,
    input  logic              mem_busy_i,
    output logic              stall_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              ex_valid_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    slot_t            r_ex;
    slot_t            r_mem;
    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;
    logic             r_ex_valid;
    logic [CNT_W-1:0] r_stall_cnt;

    slot_t      w_id_slot;
    logic       w_ex_live;
    logic       w_mem_live;
    logic       w_rs1_hit;
    logic       w_rs2_hit;
    logic       w_lu;
    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;

    assign w_id_slot = '{
        valid:     id_valid_i,
        rd:        id_rd_i,
        reg_write: id_reg_write_i,
        mem_read:  id_mem_read_i
    };

    assign w_ex_live  = slot_live(r_ex);
    assign w_mem_live = slot_live(r_mem);

    // EX.rd is non-zero whenever EX is live, so x0 can never stall
    assign w_rs1_hit = id_rs1_used_i & (id_rs1_i == r_ex.rd);
    assign w_rs2_hit = id_rs2_used_i & (id_rs2_i == r_ex.rd);
    assign w_lu      = id_valid_i & w_ex_live & r_ex.mem_read
                     & (w_rs1_hit | w_rs2_hit);

    assign stall_o = mem_busy_i | (w_lu & ~flush_i);

    fwd_select #(
        .REG_AW (REG_AW)
    ) u_sel_a (
        .i_rs          (id_rs1_i),
        .i_used        (id_rs1_used_i),
        .i_ex_live     (w_ex_live),
        .i_ex_mem_read (r_ex.mem_read),
        .i_ex_rd       (r_ex.rd),
        .i_mem_live    (w_mem_live),
        .i_mem_rd      (r_mem.rd),
        .o_sel         (w_sel_a)
    );

    fwd_select #(
        .REG_AW (REG_AW)
    ) u_sel_b (
        .i_rs          (id_rs2_i),
        .i_used        (id_rs2_used_i),
        .i_ex_live     (w_ex_live),
        .i_ex_mem_read (r_ex.mem_read),
        .i_ex_rd       (r_ex.rd),
        .i_mem_live    (w_mem_live),
        .i_mem_rd      (r_mem.rd),
        .o_sel         (w_sel_b)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ex        <= SLOT_BUBBLE;
            r_mem       <= SLOT_BUBBLE;
            r_fwd_a     <= FWD_REG;
            r_fwd_b     <= FWD_REG;
            r_ex_valid  <= 1'b0;
            r_stall_cnt <= '0;
        end else if (mem_busy_i) begin
            // frozen: every register keeps its value
        end else if (flush_i || w_lu) begin
            // bubble into EX; a flush squashes the consumer, so no stall is counted
            r_ex       <= SLOT_BUBBLE;
            r_mem      <= r_ex;
            r_fwd_a    <= FWD_REG;
            r_fwd_b    <= FWD_REG;
            r_ex_valid <= 1'b0;
            if (!flush_i && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end else begin
            r_ex       <= w_id_slot;
            r_mem      <= r_ex;
            r_fwd_a    <= w_sel_a;
            r_fwd_b    <= w_sel_b;
            r_ex_valid <= id_valid_i;
        end
    end

    assign fwd_a_o     = r_fwd_a;
    assign fwd_b_o     = r_fwd_b;
    assign ex_valid_o  = r_ex_valid;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: forwarding, load-use, flush, freeze,
// x0, counter saturation (second instance with CNT_W=4) and async reset.
module tb_hazard_fwd_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       id_valid_i;
    logic [3:0] id_rs1_i;
    logic [3:0] id_rs2_i;
    logic       id_rs1_used_i;
    logic       id_rs2_used_i;
    logic [3:0] id_rd_i;
    logic       id_reg_write_i;
    logic       id_mem_read_i;
    logic       flush_i;
    logic       mem_busy_i;

    logic        stall_o;
    logic [1:0]  fwd_a_o;
    logic [1:0]  fwd_b_o;
    logic        ex_valid_o;
    logic [31:0] stall_cnt_o;

    logic        s_stall;
    logic [1:0]  s_fwd_a;
    logic [1:0]  s_fwd_b;
    logic        s_ex_valid;
    logic [3:0]  s_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    hazard_fwd_ctrl u_dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .id_valid_i     (id_valid_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_rs1_used_i  (id_rs1_used_i),
        .id_rs2_used_i  (id_rs2_used_i),
        .id_rd_i        (id_rd_i),
        .id_reg_write_i (id_reg_write_i),
        .id_mem_read_i  (id_mem_read_i),
        .flush_i        (flush_i),
        .mem_busy_i     (mem_busy_i),
        .stall_o        (stall_o),
        .fwd_a_o        (fwd_a_o),
        .fwd_b_o        (fwd_b_o),
        .ex_valid_o     (ex_valid_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    hazard_fwd_ctrl #(
        .CNT_W (4)
    ) u_small (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .id_valid_i     (id_valid_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_rs1_used_i  (id_rs1_used_i),
        .id_rs2_used_i  (id_rs2_used_i),
        .id_rd_i        (id_rd_i),
        .id_reg_write_i (id_reg_write_i),
        .id_mem_read_i  (id_mem_read_i),
        .flush_i        (flush_i),
        .mem_busy_i     (mem_busy_i),
        .stall_o        (s_stall),
        .fwd_a_o        (s_fwd_a),
        .fwd_b_o        (s_fwd_b),
        .ex_valid_o     (s_ex_valid),
        .stall_cnt_o    (s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive one ID-stage instruction
    task automatic id(input logic v, input logic [3:0] rs1, input logic u1,
                      input logic [3:0] rs2, input logic u2,
                      input logic [3:0] rd, input logic rw, input logic mr);
        id_valid_i     = v;
        id_rs1_i       = rs1;
        id_rs1_used_i  = u1;
        id_rs2_i       = rs2;
        id_rs2_used_i  = u2;
        id_rd_i        = rd;
        id_reg_write_i = rw;
        id_mem_read_i  = mr;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni     = 1'b0;
        flush_i    = 1'b0;
        mem_busy_i = 1'b0;
        id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_fwd_a", 32'(fwd_a_o), 0);
        chk("rst_fwd_b", 32'(fwd_b_o), 0);
        chk("rst_exv", 32'(ex_valid_o), 0);
        chk("rst_cnt", stall_cnt_o, 0);

        // 1: add x5,x1,x2 ; sub x6,x5,x1
        id(1, 1, 1, 2, 1, 5, 1, 0);
        tick();
        chk("c1_add_exv", 32'(ex_valid_o), 1);
        id(1, 5, 1, 1, 1, 6, 1, 0);
        @(negedge clk_i);
        chk("c1_stall", 32'(stall_o), 0);
        tick();
        chk("c1_fwd_a", 32'(fwd_a_o), 2);
        chk("c1_fwd_b", 32'(fwd_b_o), 0);

        // 5: freeze three cycles with sub in EX, add x5 in MEM
        id(0, 0, 0, 0, 0, 0, 0, 0);
        mem_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("c5_stall", 32'(stall_o), 1);
            tick();
            chk("c5_fwd_a", 32'(fwd_a_o), 2);
            chk("c5_exv", 32'(ex_valid_o), 1);
        end
        mem_busy_i = 1'b0;
        // add x8,x6,x5: slots must still be sub x6 (EX) and add x5 (MEM)
        id(1, 6, 1, 5, 1, 8, 1, 0);
        tick();
        chk("c5_rel_a", 32'(fwd_a_o), 2);
        chk("c5_rel_b", 32'(fwd_b_o), 1);

        // 2: add x5 ; nop ; or x7,x1,x5
        id(1, 1, 1, 2, 1, 5, 1, 0);
        tick();
        id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("c2_nop_exv", 32'(ex_valid_o), 0);
        id(1, 1, 1, 5, 1, 7, 1, 0);
        tick();
        chk("c2_fwd_a", 32'(fwd_a_o), 0);
        chk("c2_fwd_b", 32'(fwd_b_o), 1);
        chk("c2_exv", 32'(ex_valid_o), 1);

        // 3: lw x3,0(x1) ; add x4,x3,x3
        id(1, 1, 1, 0, 0, 3, 1, 1);
        tick();
        id(1, 3, 1, 3, 1, 4, 1, 0);
        @(negedge clk_i);
        chk("c3_stall", 32'(stall_o), 1);
        tick();
        chk("c3_bub_exv", 32'(ex_valid_o), 0);
        chk("c3_cnt1", stall_cnt_o, 1);
        @(negedge clk_i);
        chk("c3_nostall", 32'(stall_o), 0);
        tick();
        chk("c3_fwd_a", 32'(fwd_a_o), 1);
        chk("c3_fwd_b", 32'(fwd_b_o), 1);
        chk("c3_exv", 32'(ex_valid_o), 1);
        chk("c3_cnt_hold", stall_cnt_o, 1);

        // 4: flush beats load-use
        id(1, 1, 1, 0, 0, 3, 1, 1);
        tick();
        id(1, 3, 1, 0, 1, 4, 1, 0);
        flush_i = 1'b1;
        @(negedge clk_i);
        chk("c4_stall", 32'(stall_o), 0);
        tick();
        flush_i = 1'b0;
        chk("c4_exv", 32'(ex_valid_o), 0);
        chk("c4_cnt", stall_cnt_o, 1);

        // 6a: lw x0 ; add x1,x0,x0
        id(1, 2, 1, 0, 0, 0, 1, 1);
        tick();
        id(1, 0, 1, 0, 1, 1, 1, 0);
        @(negedge clk_i);
        chk("c6_x0_stall", 32'(stall_o), 0);
        tick();
        chk("c6_x0_a", 32'(fwd_a_o), 0);
        chk("c6_x0_b", 32'(fwd_b_o), 0);
        chk("c6_x0_exv", 32'(ex_valid_o), 1);

        // saturation: 15 more load-use stalls (small counter starts at 1)
        for (int i = 0; i < 15; i++) begin
            id(1, 1, 1, 0, 0, 3, 1, 1);
            tick();
            id(1, 3, 1, 0, 0, 4, 1, 0);
            tick();
            tick();
        end
        chk("sat_cnt32", stall_cnt_o, 16);
        chk("sat_cnt4", 32'(s_cnt), 15);

        // 6b: reset asserted mid-stall
        id(1, 1, 1, 0, 0, 3, 1, 1);
        tick();
        id(1, 3, 1, 0, 0, 4, 1, 0);
        @(negedge clk_i);
        chk("c6_pre_stall", 32'(stall_o), 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("c6_rst_stall", 32'(stall_o), 0);
        chk("c6_rst_exv", 32'(ex_valid_o), 0);
        chk("c6_rst_a", 32'(fwd_a_o), 0);
        chk("c6_rst_b", 32'(fwd_b_o), 0);
        chk("c6_rst_cnt", stall_cnt_o, 0);
        chk("c6_rst_cnt4", 32'(s_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
